// File: rtl/hazard_scoreboard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard_ctrl
//  Purpose  : Hazard controller for the 5-stage MIPS pipeline. Tracks the
//             destination register and remaining Tnew of the instructions in
//             E, M and W. Compares them with the operand needs (Tuse) of the
//             D-stage instruction to produce the stall, the D/E forwarding
//             selects and a saturating stall-cycle counter.
//  Ports    : clk, rst_n             - clock, async active-low reset
//             d_rs, d_rt             - source registers of D instruction
//             d_tuse_rs, d_tuse_rt   - cycles until use (all-ones = unused)
//             d_dst, d_tnew          - destination (0 = none) and Tnew
//             stall                  - freeze PC/IF-ID, bubble into ID/EX
//             fwd_d_rs, fwd_d_rt     - 0 regfile, 1 E, 2 M, 3 W
//             fwd_e_rs, fwd_e_rt     - 0 pipe reg, 2 M, 3 W
//             cnt_clr, stall_cnt     - sync clear / saturating stall count
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard_ctrl #(
    parameter int CNT_W = 16,
    parameter int TW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic [TW-1:0]    d_tuse_rs,
    input  logic [TW-1:0]    d_tuse_rt,
    input  logic [4:0]       d_dst,
    input  logic [TW-1:0]    d_tnew,
    output logic             stall,
    output logic [1:0]       fwd_d_rs,
    output logic [1:0]       fwd_d_rt,
    output logic [1:0]       fwd_e_rs,
    output logic [1:0]       fwd_e_rt,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [TW-1:0] c_tuse_none = '1;
    localparam logic [1:0]    c_sel_none  = 2'd0;
    localparam logic [1:0]    c_sel_e     = 2'd1;
    localparam logic [1:0]    c_sel_m     = 2'd2;
    localparam logic [1:0]    c_sel_w     = 2'd3;

    // Scoreboard entries
    logic [4:0]       r_e_dst, r_e_rs, r_e_rt;
    logic [TW-1:0]    r_e_tnew;
    logic [4:0]       r_m_dst, r_m_rs, r_m_rt;
    logic [TW-1:0]    r_m_tnew;
    logic [4:0]       r_w_dst;
    logic [TW-1:0]    r_w_tnew;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_stall_rs, w_stall_rt, w_stall;

    // $0 is hard-wired, so a zero destination never produces a hazard.
    function automatic logic hit(input logic [4:0] dst, input logic [4:0] r);
        return (dst != 5'd0) && (dst == r);
    endfunction

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
        return (v == '0) ? '0 : v - TW'(1);
    endfunction

    // Only the youngest producer (E before M) decides; an older writer of
    // the same register is shadowed. W results are already in the regfile
    // path / forwardable and never cause a stall.
    function automatic logic op_stall(
        input logic [4:0]    r,
        input logic [TW-1:0] tuse,
        input logic [4:0]    e_dst,
        input logic [TW-1:0] e_tnew,
        input logic [4:0]    m_dst,
        input logic [TW-1:0] m_tnew
    );
        logic res;
        res = 1'b0;
        if (tuse != c_tuse_none) begin
            if (hit(e_dst, r))
                res = (e_tnew > tuse);
            else if (hit(m_dst, r))
                res = (m_tnew > tuse);
        end
        return res;
    endfunction

    function automatic logic [1:0] d_sel(
        input logic [4:0]    r,
        input logic [4:0]    e_dst,
        input logic [TW-1:0] e_tnew,
        input logic [4:0]    m_dst,
        input logic [TW-1:0] m_tnew,
        input logic [4:0]    w_dst,
        input logic [TW-1:0] w_tnew
    );
        logic [1:0] sel;
        sel = c_sel_none;
        if (hit(e_dst, r))
            sel = (e_tnew == '0) ? c_sel_e : c_sel_none;
        else if (hit(m_dst, r))
            sel = (m_tnew == '0) ? c_sel_m : c_sel_none;
        else if (hit(w_dst, r))
            sel = (w_tnew == '0) ? c_sel_w : c_sel_none;
        return sel;
    endfunction

    // A matching M producer that is not ready yields 0: the stall logic
    // already kept the consumer in D until this cannot happen for real uses.
    function automatic logic [1:0] e_sel(
        input logic [4:0]    r,
        input logic [4:0]    m_dst,
        input logic [TW-1:0] m_tnew,
        input logic [4:0]    w_dst,
        input logic [TW-1:0] w_tnew
    );
        logic [1:0] sel;
        sel = c_sel_none;
        if (hit(m_dst, r))
            sel = (m_tnew == '0) ? c_sel_m : c_sel_none;
        else if (hit(w_dst, r))
            sel = (w_tnew == '0) ? c_sel_w : c_sel_none;
        return sel;
    endfunction

    always_comb begin
        w_stall_rs = op_stall(d_rs, d_tuse_rs, r_e_dst, r_e_tnew, r_m_dst, r_m_tnew);
        w_stall_rt = op_stall(d_rt, d_tuse_rt, r_e_dst, r_e_tnew, r_m_dst, r_m_tnew);
        w_stall    = w_stall_rs | w_stall_rt;
    end

    assign stall     = w_stall;
    assign fwd_d_rs  = d_sel(d_rs, r_e_dst, r_e_tnew, r_m_dst, r_m_tnew, r_w_dst, r_w_tnew);
    assign fwd_d_rt  = d_sel(d_rt, r_e_dst, r_e_tnew, r_m_dst, r_m_tnew, r_w_dst, r_w_tnew);
    assign fwd_e_rs  = e_sel(r_e_rs, r_m_dst, r_m_tnew, r_w_dst, r_w_tnew);
    assign fwd_e_rt  = e_sel(r_e_rt, r_m_dst, r_m_tnew, r_w_dst, r_w_tnew);
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_dst     <= '0;
            r_e_tnew    <= '0;
            r_e_rs      <= '0;
            r_e_rt      <= '0;
            r_m_dst     <= '0;
            r_m_tnew    <= '0;
            r_m_rs      <= '0;
            r_m_rt      <= '0;
            r_w_dst     <= '0;
            r_w_tnew    <= '0;
            r_stall_cnt <= '0;
        end else begin
            // A stalled cycle sends an all-zero bubble down into E.
            if (w_stall) begin
                r_e_dst  <= '0;
                r_e_tnew <= '0;
                r_e_rs   <= '0;
                r_e_rt   <= '0;
            end else begin
                r_e_dst  <= d_dst;
                r_e_tnew <= d_tnew;
                r_e_rs   <= d_rs;
                r_e_rt   <= d_rt;
            end

            r_m_dst  <= r_e_dst;
            r_m_tnew <= sat_dec(r_e_tnew);
            r_m_rs   <= r_e_rs;
            r_m_rt   <= r_e_rt;

            r_w_dst  <= r_m_dst;
            r_w_tnew <= sat_dec(r_m_tnew);

            if (cnt_clr)
                r_stall_cnt <= '0;
            else if (w_stall && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_scoreboard_ctrl
//  Purpose  : Directed-vector bench for hazard_scoreboard_ctrl. Expected
//             outputs are queued by the stimulus process and checked by an
//             independent monitor. A second instance with a 2-bit counter
//             shares the pipeline inputs to exercise counter saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       cnt_clr, cnt_clr2;

    logic        stall, stall2;
    logic [1:0]  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
    logic [1:0]  fwd_d_rs2, fwd_d_rt2, fwd_e_rs2, fwd_e_rt2;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt2;

    always #5 clk = ~clk;

    hazard_scoreboard_ctrl #(.CNT_W(16), .TW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_dst(d_dst), .d_tnew(d_tnew),
        .stall(stall),
        .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
        .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt),
        .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard_ctrl #(.CNT_W(2), .TW(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_dst(d_dst), .d_tnew(d_tnew),
        .stall(stall2),
        .fwd_d_rs(fwd_d_rs2), .fwd_d_rt(fwd_d_rt2),
        .fwd_e_rs(fwd_e_rs2), .fwd_e_rt(fwd_e_rt2),
        .cnt_clr(cnt_clr2), .stall_cnt(stall_cnt2)
    );

    typedef struct {
        string       name;
        logic        st;
        logic [1:0]  fdrs, fdrt, fers, fert;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   failed = 0;

    // Monitor: samples 1 ns after each falling clock edge, and right after
    // an asynchronous reset assertion, whenever an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if ((stall !== e.st) || (fwd_d_rs !== e.fdrs) || (fwd_d_rt !== e.fdrt) ||
                    (fwd_e_rs !== e.fers) || (fwd_e_rt !== e.fert) || (stall_cnt !== e.cnt) ||
                    (stall2 !== e.st) || (fwd_d_rs2 !== e.fdrs) || (fwd_d_rt2 !== e.fdrt) ||
                    (fwd_e_rs2 !== e.fers) || (fwd_e_rt2 !== e.fert) || (stall_cnt2 !== e.cnt2)) begin
                    failed++;
                    $display("FAIL %s: got stall=%b fd=%0d/%0d fe=%0d/%0d cnt=%0d | b: stall=%b fd=%0d/%0d fe=%0d/%0d cnt=%0d ; want stall=%b fd=%0d/%0d fe=%0d/%0d cnt=%0d cnt2=%0d",
                             e.name, stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, stall_cnt,
                             stall2, fwd_d_rs2, fwd_d_rt2, fwd_e_rs2, fwd_e_rt2, stall_cnt2,
                             e.st, e.fdrs, e.fdrt, e.fers, e.fert, e.cnt, e.cnt2);
                end
            end
        end
    end

    task automatic drv(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] trs, input logic [1:0] trt,
                       input logic [4:0] dst, input logic [1:0] tnew);
        d_rs = rs; d_rt = rt; d_tuse_rs = trs; d_tuse_rt = trt;
        d_dst = dst; d_tnew = tnew;
    endtask

    task automatic chk(input string name, input logic st,
                       input logic [1:0] fdrs, input logic [1:0] fdrt,
                       input logic [1:0] fers, input logic [1:0] fert,
                       input logic [15:0] cnt, input logic [1:0] cnt2);
        exp_t e;
        e.name = name; e.st = st; e.fdrs = fdrs; e.fdrt = fdrt;
        e.fers = fers; e.fert = fert; e.cnt = cnt; e.cnt2 = cnt2;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; cnt_clr = 1'b0; cnt_clr2 = 1'b1;
        drv(0, 0, 3, 3, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 0, 0, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;

        // lw $1 then addu $2,$1,$3
        drv(0, 1, 1, 3, 1, 2);  chk("lw1_issue",      0, 0, 0, 0, 0, 0, 0); step();
        drv(1, 3, 1, 1, 2, 1);  chk("addu_lw_stall",  1, 0, 0, 0, 0, 0, 0); step();
                                chk("addu_lw_go",     0, 0, 0, 0, 0, 1, 0); step();
        drv(0, 0, 3, 3, 0, 0);  chk("e_fwd_w_lw",     0, 0, 0, 3, 0, 1, 0); step();
        // addu $4 then beq $4,$0
        drv(5, 6, 1, 1, 4, 1);  chk("addu4",          0, 0, 0, 0, 0, 1, 0); step();
        drv(4, 0, 0, 0, 0, 0);  chk("beq_stall",      1, 0, 0, 0, 0, 1, 0); step();
                                chk("beq_fwd_m",      0, 2, 0, 0, 0, 2, 0); step();
        // addu $5 then sw $5
        drv(7, 8, 1, 1, 5, 1);  chk("e_fwd_w_beq",    0, 0, 0, 3, 0, 2, 0); step();
        drv(9, 5, 1, 2, 0, 0);  chk("sw_no_stall",    0, 0, 0, 0, 0, 2, 0); step();
        // jal then jr $31
        drv(0, 0, 3, 3, 31, 0); chk("sw_e_fwd_m",     0, 0, 0, 0, 2, 2, 0); step();
        drv(31, 0, 0, 3, 0, 0); chk("jr_fwd_e",       0, 1, 0, 0, 0, 2, 0); step();
        // two writers of $6, then a reader: nearest (M) wins over W
        drv(0, 6, 1, 3, 6, 1);  chk("e_fwd_m_jr",     0, 0, 0, 2, 0, 2, 0); step();
                                chk("ori6_twice",     0, 0, 0, 0, 0, 2, 0); step();
        drv(0, 0, 3, 3, 0, 0);  chk("e_fwd_m_rt",     0, 0, 0, 0, 2, 2, 0); step();
        drv(6, 0, 1, 1, 7, 1);  chk("nearest_m",      0, 2, 0, 0, 0, 2, 0); step();
        // ori $0 in E, then a beq reading $0
        drv(0, 0, 1, 3, 0, 1);  chk("e_fwd_w_rs",     0, 0, 0, 3, 0, 2, 0); step();
        drv(0, 0, 0, 0, 0, 0);  chk("reg0",           0, 0, 0, 0, 0, 2, 0); step();
        // lw $9 then beq $9,$9, reset asserted mid-stall
        drv(0, 9, 1, 3, 9, 2);  chk("lw9",            0, 0, 0, 0, 0, 2, 0); step();
        drv(9, 9, 0, 0, 0, 0);  chk("beq9_stall_e",   1, 0, 0, 0, 0, 2, 0); step();
                                chk("beq9_stall_m",   1, 0, 0, 0, 0, 3, 0);
        @(negedge clk);
        #2;
        chk("rst_mid", 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; cnt_clr2 = 1'b0;
        drv(0, 9, 1, 3, 9, 2);  chk("post_rst_lw",    0, 0, 0, 0, 0, 0, 0); step();
        drv(9, 9, 0, 0, 0, 0);  chk("post_rst_stall", 1, 0, 0, 0, 0, 0, 0); step();
                                chk("stall_m2",       1, 0, 0, 0, 0, 1, 1); step();
        drv(0, 9, 1, 3, 9, 2);  chk("unused_rt_fwd",  0, 0, 3, 0, 0, 2, 2); step();
        drv(9, 9, 0, 0, 0, 0);  chk("stall_c3",       1, 0, 0, 0, 0, 2, 2); step();
                                chk("sat_edge",       1, 0, 0, 0, 0, 3, 3); step();
                                chk("sat_hold",       0, 3, 3, 0, 0, 4, 3); step();
        drv(0, 9, 1, 3, 9, 2);  chk("lw9_again",      0, 0, 0, 0, 0, 4, 3); step();
        drv(9, 9, 0, 0, 0, 0);
        cnt_clr = 1'b1; cnt_clr2 = 1'b1;
                                chk("clr_with_stall", 1, 0, 0, 0, 0, 4, 3); step();
        cnt_clr = 1'b0;
                                chk("after_clr",      1, 0, 0, 0, 0, 0, 0); step();
                                chk("count_resume",   0, 3, 3, 0, 0, 1, 0); step();

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
